// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes for load-use, branch, jump and memory waits.
// Optional stall/flush performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_use_rs1_i,
    input  logic             id_use_rs2_i,
    input  logic             id_jump_i,
    input  logic             ex_mem_rd_i,
    input  logic             ex_reg_wr_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_branch_taken_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    output logic             pc_we_o,
    output logic             if_id_we_o,
    output logic             id_ex_we_o,
    output logic             ex_mem_we_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             mem_wb_flush_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);
    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_e;

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                lu, ms;

    assign lu = ex_mem_rd_i & ex_reg_wr_i & (ex_rd_i != 5'd0) &
                ((id_use_rs1_i & (id_rs1_i == ex_rd_i)) |
                 (id_use_rs2_i & (id_rs2_i == ex_rd_i)));
    assign ms = mem_req_i & ~mem_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // wcnt counts stalled cycles already spent; ERR once it has reached the limit and memory still stalls
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN: if (ms) begin
                state_d = WAIT;
                wcnt_d  = WCNT_W'(1);
            end
            WAIT: begin
                if (!ms) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_we_o        = 1'b1;
        if_id_we_o     = 1'b1;
        id_ex_we_o     = 1'b1;
        ex_mem_we_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        mem_wb_flush_o = 1'b0;
        mem_err_o      = 1'b0;
        if (rst_i) begin
            {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o} = 4'b0000;
            {if_id_flush_o, id_ex_flush_o, mem_wb_flush_o} = 3'b111;
        end else if (state_q == ERR) begin
            {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o} = 4'b0000;
            mem_err_o = 1'b1;
        end else if (ms) begin
            {pc_we_o, if_id_we_o, id_ex_we_o, ex_mem_we_o} = 4'b0000;
            mem_wb_flush_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (lu) begin
            pc_we_o       = 1'b0;
            if_id_we_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (id_jump_i) begin
            if_id_flush_o = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we_o && state_q != ERR && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (if_id_flush_o && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
